// File: rtl/serial_adder_if.sv
// Operation/result bundle for serial_adder.
// The master side issues operations and the slave side (the adder) returns
// busy/done plus the registered result flags.
interface serial_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cOut;
    logic             overflow;

    modport master (
        output start, sub, a, b, cIn,
        input  busy, done, y, cOut, overflow
    );

    modport slave (
        input  start, sub, a, b, cIn,
        output busy, done, y, cOut, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor.
// A DIGIT-bit ripple slice of full adders is reused for WIDTH/DIGIT cycles.
// Operands sit in right-shifting registers, the running carry is held in a
// single flop, and the sum digits are shifted in from the top of a result
// register. y/cOut/overflow are only updated on the completing edge.

// One-bit full adder cell used to build the ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rstN,
    serial_adder_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // Reject illegal geometries at elaboration time.
    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic             last_digit;

    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] y_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [DIGIT:0]   carry_chain;
    logic [DIGIT-1:0] sum_digit;
    logic [WIDTH-1:0] res_shift;

    assign last_digit = (cnt_reg == LAST_CNT);

    // Ripple slice: carry_chain[0] is the stored carry, carry_chain[DIGIT]
    // is the carry out of this digit, carry_chain[DIGIT-1] the carry into
    // its top bit (the operand MSB on the last digit).
    assign carry_chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
            full_adder u_fa (
                .a  (a_reg[gi]),
                .b  (b_reg[gi]),
                .ci (carry_chain[gi]),
                .s  (sum_digit[gi]),
                .co (carry_chain[gi+1])
            );
        end
    endgenerate

    // Result assembly. Only the upper WIDTH-DIGIT bits of the partial result
    // need storing: the bottom digit of the shifted value is always dropped
    // on the next shift, except on completion where res_shift goes to y.
    generate
        if (N == 1) begin : g_single
            assign res_shift = sum_digit;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] res_hi_reg;

            // Shift each new sum digit in from the top while running.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    res_hi_reg <= '0;
                end else if (state_reg == RUN) begin
                    res_hi_reg <= res_shift[WIDTH-1:DIGIT];
                end
            end

            assign res_shift = {sum_digit, res_hi_reg};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE and DONE.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, digit shifting and counting while running.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub ? 1'b1 : bus.cIn;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> DIGIT;
            b_reg     <= b_reg >> DIGIT;
            carry_reg <= carry_chain[DIGIT];
            if (!last_digit) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Visible results load together on the final digit and otherwise hold.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            y_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (state_reg == RUN && last_digit) begin
            y_reg    <= res_shift;
            cout_reg <= carry_chain[DIGIT];
            ovf_reg  <= carry_chain[DIGIT-1] ^ carry_chain[DIGIT];
        end
    end

    assign bus.busy     = (state_reg == RUN);
    assign bus.done     = (state_reg == DONE);
    assign bus.y        = y_reg;
    assign bus.cOut     = cout_reg;
    assign bus.overflow = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three 8-bit geometries (DIGIT 1/4/2) and
// a single-cycle 16-bit instance, all sharing clock and reset.
module tb_serial_adder;
    logic clk;
    logic rst_n;

    int errors;
    int checks;

    serial_adder_if #(.WIDTH(8))  if81 ();
    serial_adder_if #(.WIDTH(8))  if84 ();
    serial_adder_if #(.WIDTH(8))  if82 ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1))  u_dut81 (.clk(clk), .rstN(rst_n), .bus(if81));
    serial_adder #(.WIDTH(8),  .DIGIT(4))  u_dut84 (.clk(clk), .rstN(rst_n), .bus(if84));
    serial_adder #(.WIDTH(8),  .DIGIT(2))  u_dut82 (.clk(clk), .rstN(rst_n), .bus(if82));
    serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (.clk(clk), .rstN(rst_n), .bus(if16));

    // Index 0: DIGIT=1 (N=8), 1: DIGIT=4 (N=2), 2: DIGIT=2 (N=4)
    logic       start8 [3];
    logic       sub8   [3];
    logic       cin8   [3];
    logic [7:0] a8     [3];
    logic [7:0] b8     [3];
    logic       busy8  [3];
    logic       done8  [3];
    logic [7:0] y8     [3];
    logic       cout8  [3];
    logic       ovf8   [3];

    assign if81.start = start8[0];
    assign if81.sub   = sub8[0];
    assign if81.cIn   = cin8[0];
    assign if81.a     = a8[0];
    assign if81.b     = b8[0];
    assign if84.start = start8[1];
    assign if84.sub   = sub8[1];
    assign if84.cIn   = cin8[1];
    assign if84.a     = a8[1];
    assign if84.b     = b8[1];
    assign if82.start = start8[2];
    assign if82.sub   = sub8[2];
    assign if82.cIn   = cin8[2];
    assign if82.a     = a8[2];
    assign if82.b     = b8[2];

    assign busy8[0] = if81.busy;
    assign done8[0] = if81.done;
    assign y8[0]    = if81.y;
    assign cout8[0] = if81.cOut;
    assign ovf8[0]  = if81.overflow;
    assign busy8[1] = if84.busy;
    assign done8[1] = if84.done;
    assign y8[1]    = if84.y;
    assign cout8[1] = if84.cOut;
    assign ovf8[1]  = if84.overflow;
    assign busy8[2] = if82.busy;
    assign done8[2] = if82.done;
    assign y8[2]    = if82.y;
    assign cout8[2] = if82.cOut;
    assign ovf8[2]  = if82.overflow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One operation on an 8-bit instance. Called and returns 1ns after an edge.
    // Operands are scrambled and start is pulsed while the unit is running.
    task automatic run8(input int idx, input string tag,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] ey, input logic ec, input logic eo);
        int n;
        n = (idx == 0) ? 8 : ((idx == 1) ? 2 : 4);
        a8[idx] = a;  b8[idx] = b;  cin8[idx] = cin;  sub8[idx] = sub;
        start8[idx] = 1'b1;
        @(posedge clk); #1;
        start8[idx] = 1'b0;
        for (int k = 0; k < n; k++) begin
            check_eq({tag, "_busy"}, 32'(busy8[idx]), 32'd1);
            check_eq({tag, "_early_done"}, 32'(done8[idx]), 32'd0);
            a8[idx]     = 8'($urandom);
            b8[idx]     = 8'($urandom);
            cin8[idx]   = 1'($urandom);
            sub8[idx]   = 1'($urandom);
            start8[idx] = (k == 1);
            @(posedge clk); #1;
        end
        start8[idx] = 1'b0;
        $display("op %s: a=%h b=%h cin=%0d sub=%0d -> y=%h cout=%0d ovf=%0d done=%0d",
                 tag, a, b, cin, sub, y8[idx], cout8[idx], ovf8[idx], done8[idx]);
        check_eq({tag, "_done"}, 32'(done8[idx]), 32'd1);
        check_eq({tag, "_busy_end"}, 32'(busy8[idx]), 32'd0);
        check_eq({tag, "_y"}, 32'(y8[idx]), 32'(ey));
        check_eq({tag, "_cout"}, 32'(cout8[idx]), 32'(ec));
        check_eq({tag, "_ovf"}, 32'(ovf8[idx]), 32'(eo));
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, 32'(done8[idx]), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, rbb, ry;
        logic        rcin, rsub, rc, rovf;
        logic [16:0] wide;
        int          seen;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start8[i] = 1'b0; sub8[i] = 1'b0; cin8[i] = 1'b0; a8[i] = '0; b8[i] = '0;
        end
        if16.start = 1'b0; if16.sub = 1'b0; if16.cIn = 1'b0; if16.a = '0; if16.b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy8[0]), 32'd0);
        check_eq("rst_done", 32'(done8[0]), 32'd0);
        check_eq("rst_y", 32'(y8[0]), 32'd0);
        check_eq("rst_y16", 32'(if16.y), 32'd0);
        check_eq("rst_flags16", 32'({if16.cOut, if16.overflow, if16.busy, if16.done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        run8(0, "add8d1", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run8(1, "add8d4", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run8(2, "sub8d2a", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run8(2, "sub8d2b", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Back-to-back with start held high: 01+02 then 7F+01
        a8[0] = 8'h01; b8[0] = 8'h02; cin8[0] = 1'b0; sub8[0] = 1'b0; start8[0] = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            check_eq("b2b1_busy", 32'(busy8[0]), 32'd1);
            a8[0] = 8'($urandom); b8[0] = 8'($urandom);
            cin8[0] = 1'($urandom); sub8[0] = 1'($urandom);
            @(posedge clk); #1;
        end
        $display("op b2b1: y=%h cout=%0d ovf=%0d done=%0d", y8[0], cout8[0], ovf8[0], done8[0]);
        check_eq("b2b1_done", 32'(done8[0]), 32'd1);
        check_eq("b2b1_res", 32'({y8[0], cout8[0], ovf8[0]}), 32'({8'h03, 1'b0, 1'b0}));
        a8[0] = 8'h7F; b8[0] = 8'h01; cin8[0] = 1'b0; sub8[0] = 1'b0;
        @(posedge clk); #1;
        check_eq("b2b2_reaccept", 32'({busy8[0], done8[0]}), 32'b10);
        check_eq("b2b2_y_held", 32'(y8[0]), 32'h03);
        for (int k = 0; k < 8; k++) begin
            check_eq("b2b2_busy", 32'(busy8[0]), 32'd1);
            a8[0] = 8'($urandom); b8[0] = 8'($urandom);
            cin8[0] = 1'($urandom); sub8[0] = 1'($urandom);
            @(posedge clk); #1;
        end
        start8[0] = 1'b0;
        $display("op b2b2: y=%h cout=%0d ovf=%0d done=%0d", y8[0], cout8[0], ovf8[0], done8[0]);
        check_eq("b2b2_done", 32'(done8[0]), 32'd1);
        check_eq("b2b2_res", 32'({y8[0], cout8[0], ovf8[0]}), 32'({8'h80, 1'b0, 1'b1}));
        @(posedge clk); #1;
        check_eq("b2b2_done_pulse", 32'(done8[0]), 32'd0);

        // Reset three cycles into an operation
        a8[0] = 8'h12; b8[0] = 8'h34; start8[0] = 1'b1;
        @(posedge clk); #1;
        start8[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("op midrst: busy=%0d done=%0d y=%h cout=%0d ovf=%0d",
                 busy8[0], done8[0], y8[0], cout8[0], ovf8[0]);
        check_eq("midrst_outs", 32'({busy8[0], done8[0], y8[0], cout8[0], ovf8[0]}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8[0] || busy8[0]) seen++;
        end
        check_eq("midrst_no_done", 32'(seen), 32'd0);
        run8(0, "after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Single-cycle 16-bit unit against an arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rcin = 1'($urandom);
            rsub = 1'($urandom);
            if (i == 0) begin ra = 16'h7FFF; rb = 16'h0001; rcin = 1'b0; rsub = 1'b0; end
            if (i == 1) begin ra = 16'h0000; rb = 16'h0001; rcin = 1'b1; rsub = 1'b1; end
            if (rsub) begin
                wide = {1'b0, ra} - {1'b0, rb};
                rc   = (ra >= rb);
                rbb  = -rb;
                ry   = wide[15:0];
                rovf = (ra[15] != rb[15]) && (ry[15] != ra[15]);
            end else begin
                wide = {1'b0, ra} + {1'b0, rb} + {16'd0, rcin};
                rc   = wide[16];
                ry   = wide[15:0];
                rovf = (ra[15] == rb[15]) && (ry[15] != ra[15]);
            end
            if16.a = ra; if16.b = rb; if16.cIn = rcin; if16.sub = rsub; if16.start = 1'b1;
            @(posedge clk); #1;
            if16.start = 1'b0;
            check_eq("w16_busy", 32'(if16.busy), 32'd1);
            @(posedge clk); #1;
            $display("op w16[%0d]: a=%h b=%h cin=%0d sub=%0d -> y=%h cout=%0d ovf=%0d",
                     i, ra, rb, rcin, rsub, if16.y, if16.cOut, if16.overflow);
            check_eq("w16_res", 32'({if16.done, if16.y, if16.cOut, if16.overflow}),
                     32'({1'b1, ry, rc, rovf}));
            if (rbb == 16'hFFFF && rsub) rbb = 16'h0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
